// File: rtl/sfm_pkg.sv
// Shared softmax datapath types and defaults: lane geometry, collector sizing,
// and the packed EXPU beat carried between the exponent unit and its consumers.
package sfm_pkg;

    localparam int SFM_N_ROWS          = 4;
    localparam int SFM_WIDTH           = 16;
    localparam int SFM_TAG_WIDTH       = 2;
    localparam int COLLECTOR_DEPTH     = 4;
    localparam int COLLECTOR_CNT_WIDTH = 16;

    typedef struct packed {
        logic [SFM_TAG_WIDTH-1:0]             tag;
        logic [SFM_N_ROWS-1:0]                strb;
        logic [SFM_N_ROWS-1:0][SFM_WIDTH-1:0] data;
    } expu_beat_t;

endpackage

// File: rtl/expu_result_collector_if.sv
// EXPU result stream: per-lane results with strobes and a beat tag under valid/ready.
interface expu_result_collector_if #(
    parameter int N_ROWS    = 4,
    parameter int WIDTH     = 16,
    parameter int TAG_WIDTH = 2
);
    logic                              valid;
    logic                              ready;
    logic [N_ROWS-1:0]                 strb;
    logic [N_ROWS-1:0][WIDTH-1:0]      res;
    logic [TAG_WIDTH-1:0]              tag;

    modport master (output valid, strb, res, tag, input ready);
    modport slave  (input valid, strb, res, tag, output ready);
endinterface

// File: rtl/sfm_lane_popcount.sv
// Counts the set lane strobes of one beat.
module sfm_lane_popcount #(
    parameter int N_ROWS = 4,
    localparam int CW    = $clog2(N_ROWS + 1)
) (
    input  logic [N_ROWS-1:0] strb_i,
    output logic [CW-1:0]     cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int l = 0; l < N_ROWS; l++) begin
            cnt_o = cnt_o + CW'(strb_i[l]);
        end
    end
endmodule

// File: rtl/expu_result_collector.sv
// First-word-fall-through sink for the EXPU result stream: masks inactive lanes,
// re-emits beats downstream in order and counts accepted active lanes.
module expu_result_collector
    import sfm_pkg::*;
#(
    // Lane geometry must match the sfm_pkg beat layout used for storage.
    parameter int N_ROWS    = SFM_N_ROWS,
    parameter int WIDTH     = SFM_WIDTH,
    parameter int TAG_WIDTH = SFM_TAG_WIDTH,
    parameter int DEPTH     = COLLECTOR_DEPTH,
    parameter int CNT_WIDTH = COLLECTOR_CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        enable_i,
    expu_result_collector_if.slave      up,
    expu_result_collector_if.master     dn,
    output logic [CNT_WIDTH-1:0]        cnt_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        busy_o
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = $clog2(N_ROWS + 1);

    logic [AW:0]          wr_ptr, rd_ptr;
    expu_beat_t           mem [DEPTH];
    expu_beat_t           wr_beat, head;
    logic                 full, empty, push, pop, store;
    logic [PCW-1:0]       pc;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_next;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Ready depends only on local state, never on downstream ready.
    assign up.ready = enable_i & ~full;
    assign dn.valid = enable_i & ~empty;
    assign push     = up.valid & up.ready;
    assign pop      = dn.valid & dn.ready;
    assign store    = push & (|up.strb);

    always_comb begin
        wr_beat.tag  = up.tag;
        wr_beat.strb = up.strb;
        for (int l = 0; l < N_ROWS; l++) begin
            wr_beat.data[l] = up.strb[l] ? up.res[l] : '0;
        end
    end

    sfm_lane_popcount #(.N_ROWS(N_ROWS)) u_popcount (
        .strb_i (up.strb),
        .cnt_o  (pc)
    );

    assign cnt_sum  = {1'b0, cnt_q} + (CNT_WIDTH+1)'(pc);
    assign cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push)  cnt_q  <= cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store && !rst_i && !clear_i) mem[wr_ptr[AW-1:0]] <= wr_beat;
    end

    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign dn.strb = head.strb;
    assign dn.res  = head.data;
    assign dn.tag  = head.tag;

    assign cnt_o   = cnt_q;
    assign full_o  = full;
    assign empty_o = empty;
    assign busy_o  = ~empty;
endmodule
